alu_issue_ctrl: RTL and testbench

//  Sequences the simple ALU datapath (opcode decoder + adder/subtractor) and shares it between two requesters.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_issue_ctrl_if.sv | 55 +++++
 rtl/rr_arbiter2.sv | 19 +
 rtl/alu_issue_ctrl.sv | 152 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode encodings, FSM states
// and the opcode legality check.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'd0;
    localparam logic [OP_W-1:0] OP_SUB = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op, input int unsigned num_ops);
        return 32'(op) < num_ops;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and response channels of the ALU issue controller.
// slave = controller view, master = requesters/ALU/consumer view.
interface alu_issue_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    import alu_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [OP_W-1:0]  req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [OP_W-1:0]  req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_ovf;
    logic             rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result, alu_ovf,
        output rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result, alu_ovf,
        input  rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. ptr is the last granted requester; on contention
// the other one wins. Pointer storage/update belongs to the caller.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one external adder/subtractor between two requesters: arbitrates,
// holds operands for EXEC_CYCLES, captures the result and returns it tagged.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned EXEC_CYCLES = 1,
    parameter int unsigned NUM_OPS     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus
);

    localparam int unsigned          CNT_W    = $clog2(EXEC_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_err_q, rsp_err_d;

    logic [1:0]       req_valid;
    logic [1:0]       grant;
    logic [1:0]       accept;
    logic             sel;
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    always_comb begin
        accept = (state_q == ST_IDLE) ? grant : '0;
        sel    = accept[1];
        sel_op = sel ? bus.req1_op : bus.req0_op;
        sel_a  = sel ? bus.req1_a  : bus.req0_a;
        sel_b  = sel ? bus.req1_b  : bus.req0_b;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|accept) begin
                    rr_ptr_d = sel;
                    rsp_id_d = sel;
                    // Illegal opcodes never reach the ALU, so its inputs keep the last legal op.
                    if (op_is_legal(sel_op, NUM_OPS)) begin
                        alu_op_d = sel_op;
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        cnt_d    = '0;
                        state_d  = ST_EXEC;
                    end else begin
                        rsp_result_d = '0;
                        rsp_ovf_d    = 1'b0;
                        rsp_err_d    = 1'b1;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_result_d = bus.alu_result;
                    rsp_ovf_d    = bus.alu_ovf;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    cnt_d        = '0;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= 1'b1;
            alu_op_q     <= OP_ADD;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // Ready is combinational from the arbiter; masking with rst_n keeps it low while reset is held.
    always_comb begin
        bus.req0_ready = accept[0] & rst_n;
        bus.req1_ready = accept[1] & rst_n;
        bus.alu_op     = alu_op_q;
        bus.alu_a      = alu_a_q;
        bus.alu_b      = alu_b_q;
        bus.rsp_valid  = rsp_valid_q;
        bus.rsp_id     = rsp_id_q;
        bus.rsp_result = rsp_result_q;
        bus.rsp_ovf    = rsp_ovf_q;
        bus.rsp_err    = rsp_err_q;
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized scoreboard bench for alu_issue_ctrl: requesters push expected
// responses at acceptance, an independent monitor pops them on each response.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int unsigned W    = 32;
    localparam int unsigned EXEC = 3;
    localparam int unsigned NOPS = 2;

    typedef struct {
        logic [OP_W-1:0] op;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
    } req_t;

    typedef struct {
        logic        id;
        logic [W-1:0] result;
        logic        ovf;
        logic        err;
        int unsigned acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(W)) bus ();

    alu_issue_ctrl #(.WIDTH(W), .EXEC_CYCLES(EXEC), .NUM_OPS(NOPS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External ALU stub: combinational adder/subtractor with signed overflow.
    logic [W-1:0] alu_r;
    always_comb begin
        alu_r = (bus.alu_op == OP_SUB) ? bus.alu_a - bus.alu_b : bus.alu_a + bus.alu_b;
        bus.alu_result = alu_r;
        if (bus.alu_op == OP_SUB)
            bus.alu_ovf = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (alu_r[W-1] != bus.alu_a[W-1]);
        else
            bus.alu_ovf = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (alu_r[W-1] != bus.alu_a[W-1]);
    end

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        sb[$];
    req_t        q0[$];
    req_t        q1[$];
    req_t        cur[2];
    bit          cur_valid[2];
    bit          eager = 1'b1;
    bit          last = 1'b1;
    int unsigned nacc = 0, ndone = 0, ndisc = 0, done_cyc = 0;
    logic [OP_W-1:0] m_op = '0;
    logic [W-1:0]    m_a = '0, m_b = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit inflight();
        return nacc != ndone + ndisc;
    endfunction

    function automatic req_t mk(input logic [OP_W-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_t r;
        r.op = op; r.a = a; r.b = b;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int unsigned k = $urandom_range(0, 9);
        r.op = (k < 8) ? OP_W'(k % 2) : OP_W'($urandom_range(2, 31));
        r.a  = $urandom;
        r.b  = $urandom;
        if ($urandom_range(0, 4) == 0) r.a = 32'h7FFF_FFFF;
        if ($urandom_range(0, 4) == 0) r.b = 32'h8000_0000;
        return r;
    endfunction

    // Reference: wide signed arithmetic, overflow = result outside W-bit signed range.
    function automatic exp_t ref_rsp(input logic id, input req_t r, input int unsigned acc);
        exp_t   e;
        longint sa, sbv, s, hi, lo;
        e.id  = id;
        e.acc = acc;
        if (r.op >= NOPS) begin
            e.result = '0; e.ovf = 1'b0; e.err = 1'b1;
        end else begin
            sa  = longint'($signed(r.a));
            sbv = longint'($signed(r.b));
            s   = (r.op == 0) ? sa + sbv : sa - sbv;
            hi  = (longint'(1) <<< (W - 1)) - 1;
            lo  = -(longint'(1) <<< (W - 1));
            e.result = s[W-1:0];
            e.ovf    = (s > hi) || (s < lo);
            e.err    = 1'b0;
        end
        return e;
    endfunction

    task automatic drive_req(input int i, input logic v, input req_t r);
        if (i == 0) begin
            bus.req0_valid = v; bus.req0_op = r.op; bus.req0_a = r.a; bus.req0_b = r.b;
        end else begin
            bus.req1_valid = v; bus.req1_op = r.op; bus.req1_a = r.a; bus.req1_b = r.b;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus.req0_ready, bus.req1_ready, bus.rsp_valid, bus.rsp_id,
                            bus.rsp_ovf, bus.rsp_err, bus.alu_op}, '0);
        chk({tag, "_alu_a"}, bus.alu_a, '0);
        chk({tag, "_alu_b"}, bus.alu_b, '0);
        chk({tag, "_rsp_result"}, bus.rsp_result, '0);
    endtask

    // One cycle of requester activity: check grants and ALU hold, record accepts, drive next.
    task automatic step();
        logic [1:0] rdy, vld, want;
        int win;
        @(negedge clk);
        rdy  = {bus.req1_ready, bus.req0_ready};
        vld  = {bus.req1_valid, bus.req0_valid};
        want = '0;
        if (rst_n && !inflight() && cyc > done_cyc)
            want = (vld == 2'b11) ? (last ? 2'b01 : 2'b10) : vld;
        chk("ready_grant", rdy, want);
        if (rst_n) begin
            chk("alu_op_hold", bus.alu_op, m_op);
            chk("alu_a_hold", bus.alu_a, m_a);
            chk("alu_b_hold", bus.alu_b, m_b);
        end
        win = -1;
        if (rdy[0] && vld[0]) win = 0;
        else if (rdy[1] && vld[1]) win = 1;
        if (win >= 0) begin
            sb.push_back(ref_rsp(win == 1, cur[win], cyc));
            nacc++;
            last = (win == 1);
            if (cur[win].op < NOPS) begin
                m_op = cur[win].op; m_a = cur[win].a; m_b = cur[win].b;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (i == win) begin
                cur_valid[i] = 1'b0;
                drive_req(i, 1'b0, cur[i]);
            end
            if (!cur_valid[i] && (eager || $urandom_range(0, 3) != 0)) begin
                if (i == 0 && q0.size() > 0) begin
                    cur[0] = q0.pop_front(); cur_valid[0] = 1'b1; drive_req(0, 1'b1, cur[0]);
                end else if (i == 1 && q1.size() > 0) begin
                    cur[1] = q1.pop_front(); cur_valid[1] = 1'b1; drive_req(1, 1'b1, cur[1]);
                end
            end
        end
    endtask

    task automatic drain(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cur_valid[0] || cur_valid[1] ||
                inflight() || sb.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s_timeout: got pending=%0d want 0", tag, sb.size());
        end
    endtask

    // Response monitor: latency, stability while stalled, payload, no spurious responses.
    initial begin : monitor
        exp_t        e;
        logic        held = 1'b0;
        logic        h_id, h_ovf, h_err;
        logic [W-1:0] h_res;
        int unsigned stall = 0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_rsp", bus.rsp_valid, 1'b0);
                end else begin
                    e = sb[0];
                    if (held) begin
                        chk("hold_id", bus.rsp_id, h_id);
                        chk("hold_result", bus.rsp_result, h_res);
                        chk("hold_ovf", bus.rsp_ovf, h_ovf);
                        chk("hold_err", bus.rsp_err, h_err);
                    end else begin
                        chk("rsp_latency", cyc - e.acc, e.err ? 1 : EXEC + 1);
                    end
                    if (bus.rsp_ready) begin
                        chk("rsp_id", bus.rsp_id, e.id);
                        chk("rsp_result", bus.rsp_result, e.result);
                        chk("rsp_ovf", bus.rsp_ovf, e.ovf);
                        chk("rsp_err", bus.rsp_err, e.err);
                        void'(sb.pop_front());
                        ndone++;
                        done_cyc = cyc;
                        if (ndone % 5 == 2) stall = 10;
                    end
                end
                held  = bus.rsp_valid && !bus.rsp_ready;
                h_id  = bus.rsp_id;
                h_res = bus.rsp_result;
                h_ovf = bus.rsp_ovf;
                h_err = bus.rsp_err;
            end else begin
                held = 1'b0;
            end
            @(posedge clk);
            #1;
            if (stall > 0) begin
                bus.rsp_ready = 1'b0;
                stall--;
            end else begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin : stim
        int unsigned n;
        bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
        cur_valid[0] = 1'b0;
        cur_valid[1] = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        q0.push_back(mk(OP_ADD, 32'd5, 32'd3));
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(OP_SUB, 32'd10, 32'd4));
            q1.push_back(mk(OP_ADD, 32'd1, 32'd1));
        end
        q1.push_back(mk(5'd7, $urandom, $urandom));
        q0.push_back(mk(OP_ADD, 32'h7FFF_FFFF, 32'd1));
        eager = 1'b1;
        drain("directed", 400);

        eager = 1'b0;
        for (int i = 0; i < 60; i++) begin
            q0.push_back(rnd_req());
            q1.push_back(rnd_req());
        end
        drain("random", 4000);

        // Reset while an op is executing: it must vanish and arbitration restart at req0.
        eager = 1'b1;
        q0.push_back(mk(OP_ADD, 32'd100, 32'd23));
        n = 0;
        while (!inflight() && n < 50) begin
            step();
            n++;
        end
        if (!inflight()) begin
            total++; bad++;
            $display("FAIL midreset_accept: got accepted=0 want 1");
        end
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        ndisc = ndisc + sb.size();
        sb.delete();
        last = 1'b1;
        m_op = '0; m_a = '0; m_b = '0;
        q0.push_back(mk(OP_ADD, 32'd2, 32'd2));
        q1.push_back(mk(OP_SUB, 32'd9, 32'd1));
        step();
        step();
        rst_n = 1'b1;
        drain("postreset", 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
